// File: rtl/servo_pwm_array.sv
// Purpose: multi-channel servo PWM driver with per-frame angle slewing and frame-aligned pulses.
// Latency: a write lands in target on the next edge; it reaches the pulse after the following frame wrap.
// Backpressure: none; writes are always accepted, and a write to a missing channel pulses wr_err.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   wr_en/wr_ch/wr_angle  target angle write (angle clamped to ANGLE_MAX)
//   en_wr/en_val          channel enable write for channel wr_ch
//   pwm                   one servo pulse per channel, high from cnt==0 for pw clocks
//   frame_start           registered, high while the frame counter is 0
//   settled               per channel, current angle equals target angle
//   wr_err                1-cycle pulse when a write names a channel >= NUM_CH
module servo_pwm_array #(
  parameter int NUM_CH     = 6,
  parameter int CLK_HZ     = 50000000,
  parameter int FRAME_HZ   = 50,
  parameter int MIN_PERMIL = 25,
  parameter int MAX_PERMIL = 125,
  parameter int ANGLE_W    = 8,
  parameter int ANGLE_MAX  = 180,
  parameter int ANGLE_RST  = 90,
  parameter int STEP_DEG   = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               wr_en,
  input  logic [3:0]         wr_ch,
  input  logic [ANGLE_W-1:0] wr_angle,
  input  logic               en_wr,
  input  logic               en_val,
  output logic [NUM_CH-1:0]  pwm,
  output logic               frame_start,
  output logic [NUM_CH-1:0]  settled,
  output logic               wr_err
);

  localparam int FRAME_CLKS = CLK_HZ / FRAME_HZ;
  localparam int MIN_CLKS   = FRAME_CLKS * MIN_PERMIL / 1000;
  localparam int MAX_CLKS   = FRAME_CLKS * MAX_PERMIL / 1000;
  // Divide before multiplying so the per-degree step is a whole number of clocks.
  localparam int SCALE      = (MAX_CLKS - MIN_CLKS) / ANGLE_MAX;
  localparam int PW_W       = $clog2(FRAME_CLKS);
  localparam int PROD_W     = PW_W + ANGLE_W;

  localparam logic [PW_W-1:0]          CNT_LAST = PW_W'(FRAME_CLKS - 1);
  localparam logic [PW_W-1:0]          PW_RST   = PW_W'(MIN_CLKS + ANGLE_RST * SCALE);
  localparam logic [ANGLE_W-1:0]       ANG_MAX  = ANGLE_MAX[ANGLE_W-1:0];
  localparam logic [ANGLE_W-1:0]       ANG_RST  = ANGLE_RST[ANGLE_W-1:0];
  localparam logic [ANGLE_W-1:0]       STEP_U   = STEP_DEG[ANGLE_W-1:0];
  localparam logic signed [ANGLE_W:0]  STEP_S   = STEP_DEG[ANGLE_W:0];

  logic [PW_W-1:0]          cnt;
  logic                     wrap;
  logic                     ch_ok;
  logic [ANGLE_W-1:0]       wr_clamped;
  logic [ANGLE_W-1:0]       target   [NUM_CH];
  logic [ANGLE_W-1:0]       cur      [NUM_CH];
  logic [ANGLE_W-1:0]       cur_next [NUM_CH];
  logic signed [ANGLE_W:0]  diff     [NUM_CH];
  logic [PW_W-1:0]          pw       [NUM_CH];
  logic [PW_W-1:0]          pw_next  [NUM_CH];
  logic [NUM_CH-1:0]        en_req;
  logic [NUM_CH-1:0]        en_act;

  assign wrap       = (cnt == CNT_LAST);
  assign ch_ok      = ({1'b0, wr_ch} < 5'(NUM_CH));
  assign wr_clamped = (wr_angle > ANG_MAX) ? ANG_MAX : wr_angle;

  // Slew toward target; the signed difference is one bit wider than the angle,
  // so a step never wraps below 0 or past the target (and hence ANGLE_MAX).
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      diff[i]     = $signed({1'b0, target[i]}) - $signed({1'b0, cur[i]});
      cur_next[i] = target[i];
      if (STEP_DEG != 0) begin
        if (diff[i] > STEP_S) begin
          cur_next[i] = cur[i] + STEP_U;
        end else if (diff[i] < -STEP_S) begin
          cur_next[i] = cur[i] - STEP_U;
        end
      end
      pw_next[i] = PW_W'(PROD_W'(MIN_CLKS) + PROD_W'(cur_next[i]) * PROD_W'(SCALE));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= '0;
      frame_start <= 1'b0;
      wr_err      <= 1'b0;
      en_req      <= '0;
      en_act      <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        target[i] <= ANG_RST;
        cur[i]    <= ANG_RST;
        pw[i]     <= PW_RST;
      end
    end else begin
      cnt         <= wrap ? '0 : cnt + PW_W'(1);
      frame_start <= wrap;
      wr_err      <= (wr_en | en_wr) & ~ch_ok;
      // Angle and enable only move at the wrap, so a pulse in flight is never cut or stretched.
      if (wrap) begin
        en_act <= en_req;
        for (int i = 0; i < NUM_CH; i++) begin
          cur[i] <= cur_next[i];
          pw[i]  <= pw_next[i];
        end
      end
      // Writes on the wrap edge update target after the frame update has read it.
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_en && (wr_ch == 4'(i))) begin
          target[i] <= wr_clamped;
        end
        if (en_wr && (wr_ch == 4'(i))) begin
          en_req[i] <= en_val;
        end
      end
    end
  end

  always_comb begin
    pwm     = '0;
    settled = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pwm[i]     = en_act[i] & (cnt < pw[i]);
      settled[i] = (cur[i] == target[i]);
    end
  end

endmodule

// File: tb/tb_servo_pwm_array.sv
module tb_servo_pwm_array;

  localparam int NCH   = 6;
  localparam int CLKHZ = 100000;
  localparam int FRHZ  = 50;
  localparam int FR    = CLKHZ / FRHZ;
  localparam int MINC  = FR * 25 / 1000;
  localparam int MAXC  = FR * 225 / 1000;
  localparam int SC    = (MAXC - MINC) / 180;
  localparam int STEP1 = 10;

  logic             clk      = 1'b0;
  logic             reset_n  = 1'b0;
  logic             wr_en    = 1'b0;
  logic [3:0]       wr_ch    = 4'd0;
  logic [7:0]       wr_angle = 8'd0;
  logic             en_wr    = 1'b0;
  logic             en_val   = 1'b0;
  logic [NCH-1:0]   pwm0, pwm1, set0, set1;
  logic             fs0, fs1, err0, err1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  servo_pwm_array #(.NUM_CH(NCH), .CLK_HZ(CLKHZ), .FRAME_HZ(FRHZ), .MIN_PERMIL(25),
                    .MAX_PERMIL(225), .STEP_DEG(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_angle(wr_angle),
    .en_wr(en_wr), .en_val(en_val), .pwm(pwm0), .frame_start(fs0), .settled(set0), .wr_err(err0));

  servo_pwm_array #(.NUM_CH(NCH), .CLK_HZ(CLKHZ), .FRAME_HZ(FRHZ), .MIN_PERMIL(25),
                    .MAX_PERMIL(225), .STEP_DEG(STEP1)) dut1 (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_angle(wr_angle),
    .en_wr(en_wr), .en_val(en_val), .pwm(pwm1), .frame_start(fs1), .settled(set1), .wr_err(err1));

  // Reference model: integer angles per instance (0: jump, 1: 10-degree slew).
  int m_cnt;
  int m_tgt [2][NCH];
  int m_cur [2][NCH];
  int m_pw  [2][NCH];
  bit m_enq [NCH];
  bit m_ena [NCH];
  bit m_fs, m_err;

  function automatic int slew(input int c, input int t, input int step);
    int d = t - c;
    if (step == 0 || (d <= step && d >= -step)) return t;
    return (d > 0) ? c + step : c - step;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_cnt <= 0;
      m_fs  <= 1'b0;
      m_err <= 1'b0;
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < NCH; i++) begin
          m_tgt[k][i] <= 90;
          m_cur[k][i] <= 90;
          m_pw[k][i]  <= MINC + 90 * SC;
        end
      for (int i = 0; i < NCH; i++) begin
        m_enq[i] <= 1'b0;
        m_ena[i] <= 1'b0;
      end
    end else begin
      m_fs  <= (m_cnt == FR - 1);
      m_err <= (wr_en || en_wr) && (int'(wr_ch) >= NCH);
      if (m_cnt == FR - 1) begin
        m_cnt <= 0;
        for (int k = 0; k < 2; k++)
          for (int i = 0; i < NCH; i++) begin
            m_cur[k][i] <= slew(m_cur[k][i], m_tgt[k][i], k == 0 ? 0 : STEP1);
            m_pw[k][i]  <= MINC + slew(m_cur[k][i], m_tgt[k][i], k == 0 ? 0 : STEP1) * SC;
          end
        for (int i = 0; i < NCH; i++) m_ena[i] <= m_enq[i];
      end else begin
        m_cnt <= m_cnt + 1;
      end
      for (int i = 0; i < NCH; i++) begin
        if (wr_en && int'(wr_ch) == i)
          for (int k = 0; k < 2; k++) m_tgt[k][i] <= (int'(wr_angle) > 180) ? 180 : int'(wr_angle);
        if (en_wr && int'(wr_ch) == i) m_enq[i] <= en_val;
      end
    end
  end

  function automatic logic [NCH-1:0] exp_pwm(input int k);
    logic [NCH-1:0] v = '0;
    for (int i = 0; i < NCH; i++) v[i] = m_ena[i] && (m_cnt < m_pw[k][i]);
    return v;
  endfunction

  function automatic logic [NCH-1:0] exp_set(input int k);
    logic [NCH-1:0] v = '0;
    for (int i = 0; i < NCH; i++) v[i] = (m_cur[k][i] == m_tgt[k][i]);
    return v;
  endfunction

  int hcnt [2][NCH];
  logic [NCH-1:0] s0_first, s1_first;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cnt(input int v);
    int n = 0;
    while (m_cnt != v && n < 3 * FR) begin
      tick();
      n++;
    end
    checks++;
    if (m_cnt != v) begin
      errors++;
      $display("FAIL wait_cnt timeout: cnt=%0d required=%0d", m_cnt, v);
    end
  endtask

  task automatic write(input int ch, input int ang, input bit we, input bit ew, input bit ev);
    wr_ch = 4'(ch); wr_angle = 8'(ang); wr_en = we; en_wr = ew; en_val = ev;
    tick();
    wr_en = 1'b0; en_wr = 1'b0;
  endtask

  // Counts high cycles per channel across one frame; call at cnt==0.
  task automatic measure_frame();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NCH; i++) hcnt[k][i] = 0;
    s0_first = set0;
    s1_first = set1;
    repeat (FR) begin
      for (int i = 0; i < NCH; i++) begin
        if (pwm0[i]) hcnt[0][i] = hcnt[0][i] + 1;
        if (pwm1[i]) hcnt[1][i] = hcnt[1][i] + 1;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({pwm0, pwm1} !== '0) begin errors++; $display("FAIL reset_pwm got=%h want=0", {pwm0, pwm1}); end
    checks++;
    if ({set0, set1} !== {2*NCH{1'b1}}) begin errors++; $display("FAIL reset_settled got=%h want=all ones", {set0, set1}); end
    checks++;
    if ({fs0, fs1, err0, err1} !== 4'b0) begin errors++; $display("FAIL reset_flags got=%b want=0000", {fs0, fs1, err0, err1}); end
    reset_n = 1'b1;
    tick();
    checks++;
    if ({pwm0, pwm1, fs0} !== '0) begin errors++; $display("FAIL post_reset got=%h want=0", {pwm0, pwm1, fs0}); end
  endtask

  task automatic test_basic();
    wait_cnt(5);
    write(0, 90, 1, 1, 1);
    write(2, 0, 1, 1, 1);
    wait_cnt(0);
    measure_frame();
    checks++;
    if (hcnt[0][0] != MINC + 90 * SC) begin errors++; $display("FAIL basic_ch0 got=%0d want=%0d", hcnt[0][0], MINC + 90 * SC); end
    checks++;
    if (hcnt[0][2] != MINC) begin errors++; $display("FAIL basic_ch2_jump got=%0d want=%0d", hcnt[0][2], MINC); end
    checks++;
    if (hcnt[1][2] != MINC + 80 * SC) begin errors++; $display("FAIL basic_ch2_slew got=%0d want=%0d", hcnt[1][2], MINC + 80 * SC); end
    checks++;
    if (hcnt[0][1] != 0 || hcnt[1][1] != 0) begin errors++; $display("FAIL basic_ch1_off got=%0d/%0d want=0", hcnt[0][1], hcnt[1][1]); end
  endtask

  task automatic test_clamp();
    write(1, 200, 1, 1, 1);
    wait_cnt(0);
    measure_frame();
    checks++;
    if (hcnt[0][1] != MINC + 180 * SC) begin errors++; $display("FAIL clamp_180 got=%0d want=%0d", hcnt[0][1], MINC + 180 * SC); end
    checks++;
    if (hcnt[1][1] != MINC + 100 * SC) begin errors++; $display("FAIL clamp_slew got=%0d want=%0d", hcnt[1][1], MINC + 100 * SC); end
    write(1, 0, 1, 0, 0);
    wait_cnt(0);
    measure_frame();
    checks++;
    if (hcnt[0][1] != MINC) begin errors++; $display("FAIL angle_zero got=%0d want=%0d", hcnt[0][1], MINC); end
  endtask

  task automatic test_wr_err();
    int exp_c [NCH];
    wait_cnt(100);
    checks++;
    if (err0 !== 1'b0) begin errors++; $display("FAIL err_idle got=%b want=0", err0); end
    write(7, 10, 1, 0, 0);
    checks++;
    if ({err0, err1} !== 2'b11) begin errors++; $display("FAIL err_pulse_ch7 got=%b want=11", {err0, err1}); end
    checks++;
    if (set0 !== exp_set(0)) begin errors++; $display("FAIL err_settled got=%b want=%b", set0, exp_set(0)); end
    tick();
    checks++;
    if (err0 !== 1'b0) begin errors++; $display("FAIL err_one_cycle got=%b want=0", err0); end
    write(6, 0, 0, 1, 1);
    checks++;
    if (err0 !== 1'b1) begin errors++; $display("FAIL err_pulse_ch6 got=%b want=1", err0); end
    tick();
    checks++;
    if (err0 !== 1'b0) begin errors++; $display("FAIL err_ch6_one_cycle got=%b want=0", err0); end
    wait_cnt(0);
    measure_frame();
    exp_c[0] = MINC + 90 * SC; exp_c[1] = MINC; exp_c[2] = MINC;
    exp_c[3] = 0; exp_c[4] = 0; exp_c[5] = 0;
    for (int i = 0; i < NCH; i++) begin
      checks++;
      if (hcnt[0][i] != exp_c[i]) begin errors++; $display("FAIL err_no_change ch%0d got=%0d want=%0d", i, hcnt[0][i], exp_c[i]); end
    end
  endtask

  task automatic test_en_clear();
    int hi = 0;
    repeat (FR) begin
      if (pwm0[0]) hi++;
      if (m_cnt == 60) begin
        wr_ch = 4'd0; en_val = 1'b0; en_wr = 1'b1;
      end else begin
        en_wr = 1'b0;
      end
      tick();
    end
    en_wr = 1'b0;
    checks++;
    if (hi != MINC + 90 * SC) begin errors++; $display("FAIL en_clear_pulse got=%0d want=%0d", hi, MINC + 90 * SC); end
    measure_frame();
    checks++;
    if (hcnt[0][0] != 0 || hcnt[1][0] != 0) begin errors++; $display("FAIL en_clear_next got=%0d/%0d want=0", hcnt[0][0], hcnt[1][0]); end
    checks++;
    if (hcnt[0][1] != MINC) begin errors++; $display("FAIL en_clear_other got=%0d want=%0d", hcnt[0][1], MINC); end
  endtask

  task automatic test_slew();
    int ang_tab [5];
    int n = 0;
    ang_tab[0] = 10; ang_tab[1] = 20; ang_tab[2] = 30; ang_tab[3] = 40; ang_tab[4] = 45;
    while (m_cur[1][2] != 0 && n < 12 * FR) begin tick(); n++; end
    checks++;
    if (m_cur[1][2] != 0) begin errors++; $display("FAIL slew_prep timeout cur=%0d want=0", m_cur[1][2]); end
    wait_cnt(1);
    checks++;
    if (set1[2] !== 1'b1) begin errors++; $display("FAIL slew_settled_before got=%b want=1", set1[2]); end
    write(2, 45, 1, 0, 0);
    checks++;
    if ({set0[2], set1[2]} !== 2'b00) begin errors++; $display("FAIL slew_settled_drop got=%b want=00", {set0[2], set1[2]}); end
    for (int f = 0; f < 5; f++) begin
      wait_cnt(0);
      measure_frame();
      checks++;
      if (hcnt[1][2] != MINC + ang_tab[f] * SC) begin errors++; $display("FAIL slew_frame%0d got=%0d want=%0d", f, hcnt[1][2], MINC + ang_tab[f] * SC); end
      checks++;
      if (s1_first[2] !== (f == 4)) begin errors++; $display("FAIL slew_settled_frame%0d got=%b want=%b", f, s1_first[2], f == 4); end
      checks++;
      if (hcnt[0][2] != MINC + 45 * SC) begin errors++; $display("FAIL slew_jump_frame%0d got=%0d want=%0d", f, hcnt[0][2], MINC + 45 * SC); end
    end
  endtask

  task automatic test_reset_mid();
    bit any = 1'b0;
    write(0, 0, 0, 1, 1);
    wait_cnt(0);
    wait_cnt(80);
    checks++;
    if (pwm0[0] !== 1'b1) begin errors++; $display("FAIL rst_mid_pre got=%b want=1", pwm0[0]); end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({pwm0, pwm1} !== '0) begin errors++; $display("FAIL rst_mid_pwm got=%h want=0", {pwm0, pwm1}); end
    tick();
    tick();
    reset_n = 1'b1;
    repeat (FR) begin
      if ((pwm0 | pwm1) != '0) any = 1'b1;
      if (m_cnt == 5) begin
        wr_ch = 4'd0; en_val = 1'b1; en_wr = 1'b1;
      end else if (m_cnt == 6) begin
        wr_ch = 4'd1;
      end else begin
        en_wr = 1'b0;
      end
      tick();
    end
    en_wr = 1'b0;
    checks++;
    if (any) begin errors++; $display("FAIL rst_first_frame got=pulse want=no pulse"); end
    measure_frame();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NCH; i++) begin
        checks++;
        if (hcnt[k][i] != ((i < 2) ? MINC + 90 * SC : 0)) begin
          errors++;
          $display("FAIL rst_targets inst%0d ch%0d got=%0d want=%0d", k, i, hcnt[k][i], (i < 2) ? MINC + 90 * SC : 0);
        end
      end
  endtask

  task automatic test_random();
    int bad = 0;
    logic [4*NCH+3:0] got, want;
    for (int c = 0; c < 6 * FR && bad < 10; c++) begin
      got  = {pwm0, pwm1, set0, set1, fs0, fs1, err0, err1};
      want = {exp_pwm(0), exp_pwm(1), exp_set(0), exp_set(1), m_fs, m_fs, m_err, m_err};
      checks++;
      if (got !== want) begin
        errors++; bad++;
        $display("FAIL random cnt=%0d got=%h want=%h", m_cnt, got, want);
      end
      if ($urandom_range(0, 29) == 0 || m_cnt == FR - 1) begin
        wr_en    = $urandom_range(0, 1) == 1;
        en_wr    = $urandom_range(0, 1) == 1;
        en_val   = $urandom_range(0, 3) != 0;
        wr_ch    = 4'($urandom_range(0, 7));
        wr_angle = 8'($urandom_range(0, 255));
      end else begin
        wr_en = 1'b0;
        en_wr = 1'b0;
      end
      tick();
    end
    wr_en = 1'b0;
    en_wr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_wr_err();
    test_en_clear();
    test_slew();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
